// File: rtl/craft_rng_pkg.sv
// Shared types and helpers for the random-number consumer blocks.
//
// Contents:
//   DEFAULT_DATA_W  - default PRNG word / bound / sample width
//   sampler_state_t - range sampler control states (IDLE, RUN, FLUSH)
//   range_mask()    - all-ones smear up to the MSB of (bound - 1); used
//                     to cut a raw word down before the rejection compare.
//                     Operates on 64 bits, so callers may be up to 64 wide.

package craft_rng_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sampler_state_t;

    // Smallest 2^k-1 mask covering bound-1. bound == 0 or 1 gives 0.
    function automatic logic [63:0] range_mask(input logic [63:0] bound);
        logic [63:0] v;
        v = (bound == 64'd0) ? 64'd0 : bound - 64'd1;
        for (int i = 1; i < 64; i = i * 2) begin
            v = v | (v >> i);
        end
        return v;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding accepted samples.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored when full or flushing)
//   push_data   - data to write
//   pop         - drop head entry (ignored when empty or flushing)
//   flush       - discard all entries this cycle; wins over push/pop
//   full, empty - registered occupancy flags
//   head        - oldest entry, valid whenever !empty
//
// The head is read straight from the storage array so a word pushed into
// an empty FIFO is visible on the very next cycle.

module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/prng_range_sampler.sv
// Range sampler: consumer end of the xor_prng stream.
//
// Pulls raw words from the generator (prng_enable), masks each to the
// smallest power-of-two range covering [0, bound) and rejects any result
// >= bound, so accepted samples are uniform with no modulo bias. Accepted
// samples are buffered in sample_fifo and served on a valid/ready port.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   cfg_valid    - strobe loading cfg_bound (any state; restarts sampling)
//   cfg_bound    - exclusive upper limit; 0 is an error and parks in IDLE
//   cfg_err      - one-cycle pulse after a zero bound is loaded
//   prng_enable  - consume prng_rand this cycle and advance the generator
//   prng_rand    - current generator word
//   out_valid/out_ready/out_data - sample stream, out_data < bound
//   reject_cnt   - saturating count of rejected draws since last cfg load
//   busy         - sampler is in RUN
//
// Optional feature (macro PRNG_SAMPLER_STATS_EN): adds stat_count (number
// of samples popped) and stat_sum (sum of popped samples), both cleared on
// reset and whenever the FIFO is flushed by a reconfiguration.

module prng_range_sampler
    import craft_rng_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_bound,
    output logic              cfg_err,
    output logic              prng_enable,
    input  logic [DATA_W-1:0] prng_rand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  reject_cnt,
    output logic              busy
`ifdef PRNG_SAMPLER_STATS_EN
    ,
    output logic [31:0]       stat_count,
    output logic [DATA_W+31:0] stat_sum
`endif
);

    sampler_state_t    state_reg;
    logic [DATA_W-1:0] bound_reg;
    logic [DATA_W-1:0] mask_reg;
    logic              run_after_flush_reg;
    logic              cfg_err_reg;
    logic [CNT_W-1:0]  reject_cnt_reg;

    logic [DATA_W-1:0] cfg_mask;
    logic [DATA_W-1:0] cand;
    logic              accept;
    logic              flush;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign cfg_mask = DATA_W'(range_mask(64'(cfg_bound)));

    // Draw gating uses only registered state and the registered full flag,
    // so out_ready never reaches prng_enable combinationally.
    assign prng_enable = (state_reg == RUN) && !fifo_full;
    assign cand        = prng_rand & mask_reg;
    assign accept      = prng_enable && (cand < bound_reg);

    // Flushing starts in the cfg cycle itself so stale samples are gone
    // from the output port by the time the FLUSH state is visible.
    assign flush = cfg_valid || (state_reg == FLUSH);
    assign pop   = out_valid && out_ready;

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_head;
    assign cfg_err    = cfg_err_reg;
    assign reject_cnt = reject_cnt_reg;
    assign busy       = (state_reg == RUN);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (cand),
        .pop       (pop),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            bound_reg           <= '0;
            mask_reg            <= '0;
            run_after_flush_reg <= 1'b0;
            cfg_err_reg         <= 1'b0;
            reject_cnt_reg      <= '0;
        end else begin
            cfg_err_reg <= 1'b0;
            if (cfg_valid) begin
                // A new cfg always wins, including over one still flushing.
                state_reg      <= FLUSH;
                reject_cnt_reg <= '0;
                if (cfg_bound == '0) begin
                    cfg_err_reg         <= 1'b1;
                    bound_reg           <= '0;
                    mask_reg            <= '0;
                    run_after_flush_reg <= 1'b0;
                end else begin
                    bound_reg           <= cfg_bound;
                    mask_reg            <= cfg_mask;
                    run_after_flush_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    FLUSH: begin
                        state_reg      <= run_after_flush_reg ? RUN : IDLE;
                        reject_cnt_reg <= '0;
                    end
                    RUN: begin
                        if (prng_enable && !accept && (reject_cnt_reg != '1)) begin
                            reject_cnt_reg <= reject_cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PRNG_SAMPLER_STATS_EN
    logic [31:0]       stat_count_reg;
    logic [DATA_W+31:0] stat_sum_reg;

    assign stat_count = stat_count_reg;
    assign stat_sum   = stat_sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_reg <= '0;
            stat_sum_reg   <= '0;
        end else if (flush) begin
            stat_count_reg <= '0;
            stat_sum_reg   <= '0;
        end else if (pop) begin
            stat_count_reg <= stat_count_reg + 32'd1;
            stat_sum_reg   <= stat_sum_reg + (DATA_W+32)'(fifo_head);
        end
    end
`endif

endmodule

// File: doc/prng_range_sampler.md
Name: prng_range_sampler

Overview:
- Consumer end of the xor_prng stream.
- Pulls raw 16-bit words by driving the generator's enable, then reduces each word to the programmed range [0, bound) by mask-and-reject. Modulo is not used, so there is no modulo bias.
- Buffers accepted samples in a small FIFO and serves them over a valid/ready interface to the ray generator, which uses them for pixel jitter and sample selection.

Parameters:
- DATA_W, 16, width of PRNG word, bound and output sample.
- FIFO_DEPTH, 4, accepted-sample buffer depth; power of two, at least 2.
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_valid  in  1  one-cycle strobe that loads a new bound.
- cfg_bound  in  DATA_W  exclusive upper limit of samples.
- cfg_err  out  1  one-cycle pulse when cfg_bound == 0 is loaded.
- prng_enable  out  1  consume current prng_rand and advance the generator.
- prng_rand  in  DATA_W  current generator word (registered in the generator).
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accepts sample.
- out_data  out  DATA_W  sample, always < bound.
- reject_cnt  out  CNT_W  rejected draws since last cfg load; saturating.
- busy  out  1  state == RUN.

Behaviour:
- Reset (async, any state): state=IDLE; FIFO empty; out_valid=0; prng_enable=0; cfg_err=0; reject_cnt=0; bound=0, mask=0.
- States:
  - IDLE: no draws.
  - RUN: drawing.
  - FLUSH: one cycle; empties the FIFO and clears reject_cnt.
- cfg_valid with cfg_bound != 0, in any state: latch bound; mask = smear of (bound-1), i.e. all ones up to the MSB of bound-1; go to FLUSH, then RUN. Samples pending in the FIFO are discarded.
- cfg_valid with cfg_bound == 0: cfg_err pulses the next cycle; FLUSH, then IDLE.
- cfg_valid during FLUSH: the newer cfg wins.
- Draw rule:
  - prng_enable = (state==RUN) && !fifo_full.
  - The word on prng_rand in the enabled cycle is consumed: cand = prng_rand & mask.
  - cand < bound: push cand. Otherwise reject_cnt++, saturating at all-ones.
- Full FIFO: no draw, even if a pop occurs in the same cycle; prng_enable depends only on registered full.
- Output: out_valid = !empty; out_data = head entry; pop on out_valid && out_ready.
  - out_data must be stable while out_valid && !out_ready.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
- Latency: a word consumed in cycle N appears at the FIFO head (out_valid) in cycle N+1 when the FIFO was empty.
- bound == 1: mask = 0; every draw is accepted with value 0.
- bound == 2^DATA_W-1: mask = all ones; only the all-ones word is rejected.
- No combinational path from out_ready to prng_enable.

Optional Feature:
- Macro: PRNG_SAMPLER_STATS_EN.
- With the macro: extra outputs stat_count (32 bits, number of accepted samples popped) and stat_sum (DATA_W+32 bits, running sum of popped out_data).
  - Both cleared on reset and on FLUSH.
  - Used on-chip for the same mean check the generator bench performs.
- Without the macro: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package craft_rng_pkg holds:
  - DATA_W default constant;
  - sampler_state_t enum {IDLE, RUN, FLUSH};
  - function range_mask(bound), which returns the bit-smear of bound-1.
- One sub-module: sample_fifo, a synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, flush, full, empty, head.
  - Instantiated once.

Test Plan (prng_rand driven from a stub table, not the real generator):
- Reset mid-RUN with the FIFO holding 3 samples → the next cycle shows out_valid=0, prng_enable=0, reject_cnt=0, busy=0.
- cfg_bound=5 (mask=7); table 0x0003, 0x0006, 0x000D, 0x0004, out_ready=1 → out_data sequence 3, 4; reject_cnt=2.
- cfg_bound=5, out_ready=0, table of all accepted words 0,1,2,3,4,0 → prng_enable drops after 4 pushes; after one pop, exactly one more draw is consumed.
- cfg_bound=1, 8 arbitrary words (e.g. 0xFFFF) → 8 outputs, all 0; reject_cnt=0.
- cfg_bound=0 while RUN with samples pending → cfg_err pulses once, FIFO empty, state IDLE, prng_enable stays 0.
- Stats build (PRNG_SAMPLER_STATS_EN), cfg_bound=16, table 1..10 all popped → stat_count=10, stat_sum=55. A reconfiguration then clears both to 0.
